uart_to_register: RTL

Receive-side counterpart of the FPGA button-array UART link. The block samples an asynchronous 8N1 serial line and reassembles four consecutive bytes, least-significant byte first, into one 32-bit word. It presents that word with a single-cycle valid strobe. It sits at the host/loopback end of the link and restores the 32-bit button array that the transmitter serialises as bytes 0..3, each sent LSB first.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_to_register_if.sv | 26 ++
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/uart_to_register.sv | 94 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART-to-register receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_to_register_if.sv
// Serial input and assembled-word outputs of the UART-to-register block.
interface uart_to_register_if;

  logic                                                            uart_rx;
  logic [uart_pkg::UART_DATA_BITS*uart_pkg::UART_BYTES_PER_WORD-1:0] data_received;
  logic                                                            data_valid;
  logic                                                            framing_error;
  logic                                                            busy;

  modport master (
    input  uart_rx,
    output data_received,
    output data_valid,
    output framing_error,
    output busy
  );

  modport slave (
    output uart_rx,
    input  data_received,
    input  data_valid,
    input  framing_error,
    input  busy
  );

endinterface

// File: rtl/uart_rx_byte.sv
// Byte-level 8N1 receiver: synchronizer, bit FSM and bit-period timer.
//
//   state | meaning
//   IDLE  | line idle; waits for a low level (only once re-armed by a high level)
//   START | timing to mid start bit to reject glitches
//   DATA  | sampling 8 data bits, LSB first, one per bit period
//   STOP  | sampling the stop bit; done/error strobe issued on that sample
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      byte_done,
  output logic                      byte_error,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cycle_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      armed;
  logic                      tick;

  assign rx_s = sync_q[1];
  // The bit timer is a down-counter; a sample is taken on its terminal count.
  assign tick = (cycle_cnt == '0);

  // Two-flop synchronizer for the asynchronous line, resetting to idle-high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  // Bit FSM with bit-period timer; after a bad stop bit, stay disarmed until the line is seen high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      armed     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= START;
            cycle_cnt <= HALF_RELOAD;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              bit_idx   <= '0;
              cycle_cnt <= FULL_RELOAD;
            end
          end else begin
            cycle_cnt <= cycle_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q[bit_idx] <= rx_s;
            cycle_cnt        <= FULL_RELOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            if (!rx_s) begin
              armed <= 1'b0;
            end
          end else begin
            cycle_cnt <= cycle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are combinational on the stop sample so the word logic can register them with one cycle of latency.
  assign byte_done  = (state == STOP) && tick && rx_s;
  assign byte_error = (state == STOP) && tick && !rx_s;
  assign byte_data  = shift_q;
  assign busy       = (state != IDLE);

endmodule

// File: rtl/uart_to_register.sv
// Reassembles four LSB-first UART bytes into a 32-bit word with a valid strobe.
module uart_to_register
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clock,
  input  logic                reset_n,
  uart_to_register_if.master  bus
);

  localparam int WORD_W         = UART_DATA_BITS * UART_BYTES_PER_WORD;
  localparam int PART_W         = WORD_W - UART_DATA_BITS;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAST_SLOT  = 2'(UART_BYTES_PER_WORD - 1);

  logic [UART_DATA_BITS-1:0] byte_data;
  logic                      byte_done;
  logic                      byte_error;
  logic                      rx_busy;

  logic [1:0]                byte_count;
  logic [PART_W-1:0]         partial_q;
  logic [WORD_W-1:0]         data_q;
  logic                      valid_q;
  logic                      error_q;
  logic [TMO_W-1:0]          idle_cnt;
  logic                      timeout_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clock      (clock),
    .reset_n    (reset_n),
    .uart_rx    (bus.uart_rx),
    .byte_data  (byte_data),
    .byte_done  (byte_done),
    .byte_error (byte_error),
    .busy       (rx_busy)
  );

  // Idle time only matters with a partial word pending; the counter fires on its final idle cycle.
  assign timeout_hit = !rx_busy && (byte_count != 2'd0) && (idle_cnt == '0);

  // Idle-time down-counter; any receiver activity (including a false start) reloads it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (rx_busy || (byte_count == 2'd0)) begin
      idle_cnt <= TMO_RELOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  // Word assembly: slots 0..2 buffer, slot 3 publishes; framing errors and timeouts drop the partial word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_count <= 2'd0;
      partial_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (byte_done) begin
        if (byte_count == LAST_SLOT) begin
          data_q  <= {byte_data, partial_q};
          valid_q <= 1'b1;
        end else begin
          partial_q[{byte_count, 3'b000} +: UART_DATA_BITS] <= byte_data;
        end
        byte_count <= byte_count + 1'b1;
      end else if (byte_error) begin
        error_q    <= 1'b1;
        byte_count <= 2'd0;
        partial_q  <= '0;
      end else if (timeout_hit) begin
        byte_count <= 2'd0;
        partial_q  <= '0;
      end
    end
  end

  assign bus.data_received = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.framing_error = error_q;
  assign bus.busy          = rx_busy;

endmodule
